// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of an asynchronous FIFO.
// Brings the Gray write pointer into the read clock domain and keeps the
// binary and Gray read pointers. It also produces the registered empty flag
// and the count of words not yet fetched. Fetched words land in a 2-entry
// first-word-fall-through output stage with a valid/ready handshake.
module fifo_rd_ctrl #(
    parameter int Depth     = 8,
    parameter int Width     = 8,
    parameter int Ptr_Width = 3
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [Ptr_Width:0]   g_wptr,
    input  logic [Width-1:0]     mem_rdata,
    input  logic                 dout_ready,
    output logic                 r_en,
    output logic [Ptr_Width:0]   b_rptr,
    output logic [Ptr_Width:0]   g_rptr,
    output logic                 empty,
    output logic [Ptr_Width:0]   rd_count,
    output logic [Width-1:0]     dout,
    output logic                 dout_valid
);

    // Pointer width including the wrap bit.
    localparam int PW = Ptr_Width + 1;

    // Write-pointer synchroniser stages and the decoded binary write pointer.
    logic [PW-1:0]    wq1_q;
    logic [PW-1:0]    wq2_q;
    logic [PW-1:0]    wbin;

    // Read pointers and memory status.
    logic [PW-1:0]    b_rptr_q;
    logic [PW-1:0]    b_rptr_d;
    logic [PW-1:0]    g_rptr_q;
    logic [PW-1:0]    g_rptr_d;
    logic             empty_q;
    logic             empty_d;
    logic [PW-1:0]    rd_count_q;
    logic [PW-1:0]    rd_count_d;
    logic [PW-1:0]    rd_diff;

    // Output stage: two-entry ring with a head index and an occupancy count.
    // inflight_q marks that mem_rdata carries a fetched word this cycle.
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic             inflight_q;
    logic             head_q;
    logic             head_d;
    logic             wr_idx;
    logic [Width-1:0] buf_q [2];

    logic             pop;
    logic             fetch;
    logic [2:0]       fill;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of this Gray bit and every Gray bit above it.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wbin[gi] = ^(wq2_q >> gi);
        end
    endgenerate

    // Two-flop synchroniser for the Gray write pointer. It changes one bit per
    // step, so a sample taken mid-change is either the old or the new value.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wq1_q <= '0;
            wq2_q <= '0;
        end else begin
            wq1_q <= g_wptr;
            wq2_q <= wq1_q;
        end
    end

    // Fetch decision, next pointers, status and output-stage bookkeeping.
    always_comb begin
        pop        = dout_valid & dout_ready;
        // Number of words held or arriving after this cycle's pop. A new fetch
        // is allowed only if that leaves room, so the stage never overflows.
        fill       = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        fetch      = rrst_n && !empty_q && (fill <= 3'd1);
        b_rptr_d   = b_rptr_q + PW'(fetch);
        g_rptr_d   = bin2gray(b_rptr_d);
        empty_d    = (g_rptr_d == wq2_q);
        rd_diff    = wbin - b_rptr_d;
        // In normal operation the difference never exceeds Depth. The clamp
        // keeps the count meaningful if the write side ever hands over a
        // corrupt pointer.
        rd_count_d = (rd_diff > PW'(Depth)) ? PW'(Depth) : rd_diff;
        occ_d      = occ_q + 2'(inflight_q) - 2'(pop);
        head_d     = head_q ^ pop;
        // An arriving word goes into the slot just behind the oldest one. When
        // occ is 1 and a pop happens together with the arrival, that slot
        // becomes the new head, so the order is kept.
        wr_idx     = head_q ^ occ_q[0];
    end

    // Read pointers, empty flag and the fill count are all registered.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr_q   <= '0;
            g_rptr_q   <= '0;
            empty_q    <= 1'b1;
            rd_count_q <= '0;
        end else begin
            b_rptr_q   <= b_rptr_d;
            g_rptr_q   <= g_rptr_d;
            empty_q    <= empty_d;
            rd_count_q <= rd_count_d;
        end
    end

    // Output-stage occupancy, head index and the one-cycle memory latency marker.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_q      <= '0;
            head_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            inflight_q <= fetch;
        end
    end

    // Output-stage storage. Each slot captures mem_rdata when it is the write target.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n) begin
                    buf_q[gi] <= '0;
                end else if (inflight_q && (wr_idx == 1'(gi))) begin
                    buf_q[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign r_en       = fetch;
    assign b_rptr     = b_rptr_q;
    assign g_rptr     = g_rptr_q;
    assign empty      = empty_q;
    assign rd_count   = rd_count_q;
    assign dout       = buf_q[head_q];
    assign dout_valid = (occ_q != 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl. A behavioural memory and write side feed the DUT.
// Every word written is pushed to a scoreboard. Each accepted output beat pops
// the scoreboard and is compared against it.
module tb_fifo_rd_ctrl;

    typedef struct {
        int         nwords;
        logic       ready;
        int         waitc;
        logic       exp_empty;
        logic [3:0] exp_cnt;
        logic       exp_valid;
    } vec_t;

    logic       clk;
    logic       rrst_n;
    logic [3:0] g_wptr;
    logic [7:0] mem_rdata;
    logic       dout_ready;
    logic       r_en;
    logic [3:0] b_rptr;
    logic [3:0] g_rptr;
    logic       empty;
    logic [3:0] rd_count;
    logic [7:0] dout;
    logic       dout_valid;

    logic [7:0] tb_mem [8];
    logic [7:0] sb [$];

    int         tests;
    int         fails;
    int         wcnt;
    int         cyc;
    int         en_cnt;
    int         pop_cnt;
    int         last_en_cyc;
    int         last_pop_cyc;
    int         wraps;
    logic [3:0] exp_rptr;
    logic [3:0] prev_g;
    vec_t       vecs [5];

    fifo_rd_ctrl #(.Depth(8), .Width(8), .Ptr_Width(3)) dut (
        .rclk       (clk),
        .rrst_n     (rrst_n),
        .g_wptr     (g_wptr),
        .mem_rdata  (mem_rdata),
        .dout_ready (dout_ready),
        .r_en       (r_en),
        .b_rptr     (b_rptr),
        .g_rptr     (g_rptr),
        .empty      (empty),
        .rd_count   (rd_count),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The memory returns the word one cycle after the strobe.
    always @(posedge clk) begin
        if (r_en) mem_rdata <= tb_mem[b_rptr[2:0]];
    end

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Checks the fetch sequence, Gray steps and the scoreboard on every falling edge.
    task automatic observe();
        logic [7:0] exp_d;
        if (!rrst_n) begin
            chk("r_en_in_reset", 32'(r_en), 32'(0));
        end else begin
            if (r_en) begin
                chk("fetch_not_empty", 32'(empty), 32'(0));
                chk("rptr_seq", 32'(b_rptr), 32'(exp_rptr));
                if (b_rptr == 4'd15) wraps++;
                exp_rptr = exp_rptr + 4'd1;
                en_cnt++;
                last_en_cyc = cyc;
            end
            if (dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(1), 32'(0));
                end else begin
                    exp_d = sb.pop_front();
                    chk("dout_order", 32'(dout), 32'(exp_d));
                end
                pop_cnt++;
                last_pop_cyc = cyc;
            end
        end
        if (g_rptr !== prev_g) begin
            chk("gray_one_bit", 32'($countones(g_rptr ^ prev_g)), 32'(1));
            chk("gray_matches_bin", 32'(g_rptr), 32'(b2g(b_rptr)));
            prev_g = g_rptr;
        end
        cyc++;
    endtask

    // One clock: observe at the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        logic [3:0] w4;
        tb_mem[wcnt % 8] = d;
        wcnt = wcnt + 1;
        w4 = 4'(wcnt);
        g_wptr = b2g(w4);
        sb.push_back(d);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_empty"},    32'(empty),      32'(1));
        chk({tag, "_valid"},    32'(dout_valid), 32'(0));
        chk({tag, "_r_en"},     32'(r_en),       32'(0));
        chk({tag, "_b_rptr"},   32'(b_rptr),     32'(0));
        chk({tag, "_g_rptr"},   32'(g_rptr),     32'(0));
        chk({tag, "_rd_count"}, 32'(rd_count),   32'(0));
        chk({tag, "_dout"},     32'(dout),       32'(0));
    endtask

    // Asserts reset in the middle of a cycle, so only the asynchronous path can
    // clear the outputs before the check.
    task automatic do_reset(input string tag);
        #2;
        rrst_n = 1'b0;
        #1;
        reset_checks(tag);
        g_wptr   = 4'd0;
        wcnt     = 0;
        en_cnt   = 0;
        exp_rptr = 4'd0;
        prev_g   = 4'd0;
        sb.delete();
        repeat (3) tick();
        rrst_n = 1'b1;
    endtask

    initial begin
        int n;
        int base_en;
        int base_pop;
        int first_en;
        int pushed;
        logic [7:0] d0;

        tests = 0; fails = 0; wcnt = 0; cyc = 0; en_cnt = 0; pop_cnt = 0;
        last_en_cyc = 0; last_pop_cyc = 0; wraps = 0;
        exp_rptr = 4'd0; prev_g = 4'd0;
        for (int i = 0; i < 8; i++) tb_mem[i] = 8'h00;
        rrst_n = 1'b1; g_wptr = 4'b0101; dout_ready = 1'b0;

        vecs[0] = '{nwords: 3, ready: 1'b0, waitc: 8,  exp_empty: 1'b0, exp_cnt: 4'd1, exp_valid: 1'b1};
        vecs[1] = '{nwords: 0, ready: 1'b1, waitc: 8,  exp_empty: 1'b1, exp_cnt: 4'd0, exp_valid: 1'b0};
        vecs[2] = '{nwords: 8, ready: 1'b0, waitc: 8,  exp_empty: 1'b0, exp_cnt: 4'd6, exp_valid: 1'b1};
        vecs[3] = '{nwords: 0, ready: 1'b1, waitc: 12, exp_empty: 1'b1, exp_cnt: 4'd0, exp_valid: 1'b0};
        vecs[4] = '{nwords: 1, ready: 1'b1, waitc: 8,  exp_empty: 1'b1, exp_cnt: 4'd0, exp_valid: 1'b0};

        // 1. Reset with a non-zero write pointer, then measure the empty-release latency.
        #3;
        rrst_n = 1'b0;
        #1;
        reset_checks("t1_rst");
        repeat (3) tick();
        rrst_n = 1'b1;
        tick(); chk("t1_empty_edge1", 32'(empty), 32'(1));
        tick(); chk("t1_empty_edge2", 32'(empty), 32'(1));
        tick(); chk("t1_empty_edge3", 32'(empty), 32'(0));
        chk("t1_rd_count", 32'(rd_count), 32'(6));
        do_reset("t1_rerst");

        // 2. Single word.
        base_en = en_cnt;
        push(8'hA5);
        n = 0;
        while (!dout_valid && n < 20) begin tick(); n++; end
        chk("t2_valid", 32'(dout_valid), 32'(1));
        chk("t2_dout", 32'(dout), 32'(8'hA5));
        dout_ready = 1'b1;
        tick();
        chk("t2_fetches", 32'(en_cnt - base_en), 32'(1));
        chk("t2_valid_after", 32'(dout_valid), 32'(0));
        chk("t2_empty", 32'(empty), 32'(1));
        chk("t2_b_rptr", 32'(b_rptr), 32'(1));
        chk("t2_g_rptr", 32'(g_rptr), 32'(4'b0001));

        // 3. Burst of 8 with the consumer always ready.
        base_en = en_cnt; base_pop = pop_cnt;
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        n = 0;
        while (!r_en && n < 20) begin tick(); n++; end
        first_en = cyc;
        repeat (14) tick();
        chk("t3_fetches", 32'(en_cnt - base_en), 32'(8));
        chk("t3_fetch_span", 32'(last_en_cyc - first_en), 32'(7));
        chk("t3_beats", 32'(pop_cnt - base_pop), 32'(8));
        chk("t3_beat_last", 32'(last_pop_cyc - first_en), 32'(9));
        chk("t3_rd_count", 32'(rd_count), 32'(0));
        chk("t3_empty", 32'(empty), 32'(1));
        chk("t3_sb_drained", 32'(sb.size()), 32'(0));

        // 4. Backpressure: only two fetches, and the head word is held stable.
        dout_ready = 1'b0;
        base_en = en_cnt; base_pop = pop_cnt;
        for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
        repeat (10) tick();
        chk("t4_fetches", 32'(en_cnt - base_en), 32'(2));
        chk("t4_rd_count", 32'(rd_count), 32'(6));
        chk("t4_valid", 32'(dout_valid), 32'(1));
        chk("t4_head", 32'(dout), 32'(8'hC0));
        d0 = dout;
        repeat (5) tick();
        chk("t4_dout_stable", 32'(dout), 32'(d0));
        chk("t4_valid_stable", 32'(dout_valid), 32'(1));
        dout_ready = 1'b1;
        repeat (14) tick();
        chk("t4_beats", 32'(pop_cnt - base_pop), 32'(8));
        chk("t4_sb_drained", 32'(sb.size()), 32'(0));

        // 5. Stream 20 words through the pointer wrap.
        pushed = 0; n = 0; wraps = 0;
        while ((pushed < 20 || sb.size() != 0) && n < 300) begin
            if (pushed < 20 && (wcnt - en_cnt) < 8) begin
                push(8'($urandom_range(0, 255)));
                pushed++;
            end
            tick();
            n++;
        end
        chk("t5_drained", 32'(sb.size()), 32'(0));
        chk("t5_wrap_seen", 32'(wraps > 0), 32'(1));
        chk("t5_empty", 32'(empty), 32'(1));

        // Table of fill/drain steps starting from an empty FIFO.
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < vecs[i].nwords; k++) push(8'($urandom_range(0, 255)));
            dout_ready = vecs[i].ready;
            repeat (vecs[i].waitc) tick();
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_rd_count", i), 32'(rd_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
        end

        // 6. Reset in the middle of a burst, then confirm normal operation resumes.
        dout_ready = 1'b1;
        base_en = en_cnt;
        for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
        n = 0;
        while ((en_cnt - base_en) < 3 && n < 20) begin tick(); n++; end
        chk("t6_burst_started", 32'((en_cnt - base_en) >= 3), 32'(1));
        do_reset("t6_rst");
        push(8'h5A);
        push(8'h3C);
        repeat (12) tick();
        chk("t6_after_drained", 32'(sb.size()), 32'(0));
        chk("t6_after_b_rptr", 32'(b_rptr), 32'(2));
        chk("t6_after_empty", 32'(empty), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
